// File: rtl/pc_stack.sv
// Program counter with absolute/relative jumps and a LIFO return-address stack.
// Commands are one-hot by priority: load > call > ret > rel > inc > hold.
module pc_stack #(
  parameter int            N         = 8,
  parameter int            DEPTH     = 4,
  parameter logic [N-1:0]  RESET_VEC = {N{1'b0}}
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       inc,
  input  logic                       load,
  input  logic [N-1:0]               d,
  input  logic                       rel,
  input  logic [N-1:0]               off,
  input  logic                       call,
  input  logic                       ret,
  input  logic                       err_clr,
  output logic [N-1:0]               q,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       full,
  output logic                       empty,
  output logic                       err
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);
  localparam logic [DW-1:0] DEPTH_ONE = {{(DW-1){1'b0}}, 1'b1};
  localparam logic [N-1:0]  PC_ONE    = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0]  q_r, q_nxt_s;
  logic [DW-1:0] depth_r, depth_nxt_s;
  logic          err_r, err_nxt_s;
  logic          full_r, empty_r;
  logic          push_s, fault_s;
  logic [N-1:0]  pc_plus1_s;
  logic [AW-1:0] wr_idx_s, top_idx_s;
  logic [N-1:0]  stack_r [DEPTH];

  assign pc_plus1_s = q_r + PC_ONE;
  assign wr_idx_s   = AW'(depth_r);
  assign top_idx_s  = AW'(depth_r - DEPTH_ONE);

  // Next-state selection by fixed command priority.
  always_comb begin
    q_nxt_s     = q_r;
    depth_nxt_s = depth_r;
    push_s      = 1'b0;
    fault_s     = 1'b0;
    if (load) begin
      q_nxt_s = d;
    end else if (call) begin
      if (full_r) begin
        fault_s = 1'b1;
      end else begin
        push_s      = 1'b1;
        depth_nxt_s = depth_r + DEPTH_ONE;
        q_nxt_s     = d;
      end
    end else if (ret) begin
      if (empty_r) begin
        fault_s = 1'b1;
      end else begin
        q_nxt_s     = stack_r[top_idx_s];
        depth_nxt_s = depth_r - DEPTH_ONE;
      end
    end else if (rel) begin
      q_nxt_s = q_r + off;
    end else if (inc) begin
      q_nxt_s = pc_plus1_s;
    end else begin
      q_nxt_s = q_r;
    end
    // A new fault outranks a simultaneous clear.
    err_nxt_s = fault_s | (err_r & ~err_clr);
  end

  // Counter, stack pointer and flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_r     <= RESET_VEC;
      depth_r <= {DW{1'b0}};
      err_r   <= 1'b0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
    end else begin
      q_r     <= q_nxt_s;
      depth_r <= depth_nxt_s;
      err_r   <= err_nxt_s;
      full_r  <= (depth_nxt_s == DEPTH_MAX);
      empty_r <= (depth_nxt_s == {DW{1'b0}});
    end
  end

  // Return-address storage; contents are only read while occupied, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      stack_r[wr_idx_s] <= pc_plus1_s;
    end else begin
      stack_r[wr_idx_s] <= stack_r[wr_idx_s];
    end
  end

  assign q     = q_r;
  assign depth = depth_r;
  assign full  = full_r;
  assign empty = empty_r;
  assign err   = err_r;

endmodule

// File: tb/tb_pc_stack.sv
// Self-checking bench for pc_stack: directed plan steps plus random commands
// compared against a queue-based reference model.
module tb_pc_stack;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       inc = 1'b0, load = 1'b0, rel = 1'b0, call = 1'b0, ret = 1'b0, err_clr = 1'b0;
  logic [7:0] d = 8'h00, off = 8'h00;
  logic [7:0] q;
  logic [2:0] depth;
  logic       full, empty, err;

  logic       b_ret = 1'b0;
  logic [7:0] b_q;
  logic [2:0] b_depth;
  logic       b_full, b_empty, b_err;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] m_q = 8'h00;
  logic [7:0] m_stack[$];
  logic       m_err = 1'b0;

  pc_stack #(.N(8), .DEPTH(4), .RESET_VEC(8'h00)) u_dut (
    .clk(clk), .reset(rst_n), .inc(inc), .load(load), .d(d), .rel(rel), .off(off),
    .call(call), .ret(ret), .err_clr(err_clr),
    .q(q), .depth(depth), .full(full), .empty(empty), .err(err)
  );

  pc_stack #(.N(8), .DEPTH(4), .RESET_VEC(8'hA5)) u_vec (
    .clk(clk), .reset(rst_n), .inc(1'b0), .load(1'b0), .d(8'h00), .rel(1'b0), .off(8'h00),
    .call(1'b0), .ret(b_ret), .err_clr(1'b0),
    .q(b_q), .depth(b_depth), .full(b_full), .empty(b_empty), .err(b_err)
  );

  always #5 clk = ~clk;

  task automatic cmd(input logic i_inc, input logic i_load, input logic [7:0] i_d,
                     input logic i_rel, input logic [7:0] i_off,
                     input logic i_call, input logic i_ret, input logic i_clr);
    inc = i_inc; load = i_load; d = i_d; rel = i_rel; off = i_off;
    call = i_call; ret = i_ret; err_clr = i_clr;
  endtask

  task automatic idle();
    cmd(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic model_reset();
    m_q = 8'h00;
    m_stack.delete();
    m_err = 1'b0;
  endtask

  // Reference behaviour: one command wins, the rest are ignored.
  task automatic model_step();
    logic fault;
    fault = 1'b0;
    if (load) m_q = d;
    else if (call) begin
      if (m_stack.size() == 4) fault = 1'b1;
      else begin
        m_stack.push_back(m_q + 8'd1);
        m_q = d;
      end
    end else if (ret) begin
      if (m_stack.size() == 0) fault = 1'b1;
      else m_q = m_stack.pop_back();
    end else if (rel) m_q = m_q + off;
    else if (inc) m_q = m_q + 8'd1;
    if (fault) m_err = 1'b1;
    else if (err_clr) m_err = 1'b0;
  endtask

  task automatic check_all(input string tag);
    logic [2:0] exp_depth;
    exp_depth = 3'(m_stack.size());
    vectors++;
    assert (q === m_q) else begin
      miscompares++; $error("FAIL %s q: got %h want %h", tag, q, m_q);
    end
    vectors++;
    assert (depth === exp_depth) else begin
      miscompares++; $error("FAIL %s depth: got %0d want %0d", tag, depth, exp_depth);
    end
    vectors++;
    assert (full === (exp_depth == 3'd4)) else begin
      miscompares++; $error("FAIL %s full: got %b want %b", tag, full, exp_depth == 3'd4);
    end
    vectors++;
    assert (empty === (exp_depth == 3'd0)) else begin
      miscompares++; $error("FAIL %s empty: got %b want %b", tag, empty, exp_depth == 3'd0);
    end
    vectors++;
    assert (err === m_err) else begin
      miscompares++; $error("FAIL %s err: got %b want %b", tag, err, m_err);
    end
  endtask

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++; $error("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    #1;
    model_step();
    check_all(tag);
  endtask

  initial begin
    // 1. reset, inc/load basics
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;
    cmd(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0); cycle("inc");
    cmd(1'b0, 1'b1, 8'hF0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0); cycle("load");
    cmd(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0); cycle("inc_f1");
    cmd(1'b1, 1'b1, 8'hF0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0); cycle("inc_load");
    cmd(1'b0, 1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0); cycle("load_ff");
    cmd(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0); cycle("inc_wrap");
    check_val("inc_wrap_abs", q, 8'h00);

    // 2. nested call/return
    cmd(1'b0, 1'b1, 8'h10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0); cycle("load_10");
    cmd(1'b0, 1'b0, 8'h40, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0); cycle("call_40");
    cmd(1'b0, 1'b0, 8'h80, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0); cycle("call_80");
    cmd(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0); cycle("ret_41");
    check_val("ret_41_abs", q, 8'h41);
    cmd(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0); cycle("ret_11");
    check_val("ret_11_abs", q, 8'h11);

    // 3. fill, overflow, clear, drain, underflow (first call wraps 0xFF -> push 0)
    cmd(1'b0, 1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0); cycle("load_ff2");
    for (int i = 0; i < 4; i++) begin
      cmd(1'b0, 1'b0, 8'(8'h30 + 8'(i) * 8'h10), 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      cycle("fill");
    end
    cmd(1'b0, 1'b0, 8'h99, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0); cycle("overflow");
    cmd(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1); cycle("err_clr");
    for (int i = 0; i < 4; i++) begin
      cmd(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      cycle("drain");
    end
    check_val("wrap_push_0", q, 8'h00);
    cmd(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0); cycle("underflow");

    // 4. relative branches
    cmd(1'b0, 1'b1, 8'h05, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0); cycle("load_05");
    cmd(1'b0, 1'b0, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0); cycle("rel_m2");
    cmd(1'b0, 1'b0, 8'h00, 1'b1, 8'h7F, 1'b0, 1'b0, 1'b0); cycle("rel_7f");
    check_val("rel_7f_abs", q, 8'h82);
    cmd(1'b0, 1'b1, 8'hF0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0); cycle("load_f0");
    cmd(1'b0, 1'b0, 8'h00, 1'b1, 8'h20, 1'b0, 1'b0, 1'b0); cycle("rel_wrap");
    cmd(1'b1, 1'b0, 8'h00, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0); cycle("rel_inc");

    // 5. priority collisions
    cmd(1'b0, 1'b1, 8'h33, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0); cycle("load_call");
    cmd(1'b0, 1'b0, 8'h50, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0); cycle("call_d1");
    cmd(1'b0, 1'b0, 8'h60, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0); cycle("call_ret");
    cmd(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0); cycle("pop1");
    cmd(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0); cycle("pop2");
    cmd(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1); cycle("clr_vs_unf");

    // random commands
    for (int n = 0; n < 400; n++) begin
      cmd(($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), 8'($urandom),
          ($urandom_range(0, 4) == 0), 8'($urandom),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 5) == 0));
      cycle("random");
    end

    // 6. async reset mid-cycle with depth=3, err=1
    idle();
    cmd(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1); cycle("pre_clr");
    while (m_stack.size() != 0) begin
      cmd(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0); cycle("pre_drain");
    end
    cmd(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0); cycle("pre_unf");
    for (int i = 0; i < 3; i++) begin
      cmd(1'b0, 1'b0, 8'(8'hC0 + 8'(i)), 1'b0, 8'h00, 1'b1, 1'b0, 1'b0); cycle("pre_call");
    end
    idle();
    @(posedge clk);
    #1;
    model_step();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    check_val("vec_reset_q", b_q, 8'hA5);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_all("post_reset");
    b_ret = 1'b1;
    cycle("vec_hold");
    b_ret = 1'b0;
    check_val("vec_ret_err", {7'h00, b_err}, 8'h01);
    check_val("vec_ret_q", b_q, 8'hA5);
    check_val("vec_ret_depth", {5'h00, b_depth}, 8'h00);
    cmd(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0); cycle("ret_after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_stack.md
Name: pc_stack

Overview:
- Parametrised program counter for the 8-bit CPU core and its wider derivatives.
- Keeps the existing inc/load behaviour, with load taking priority over inc.
- Adds signed relative branch, subroutine call/return through an internal LIFO return-address stack of configurable depth, and a configurable reset vector.
- Sits between the control sequencer and the memory address register; q drives the address bus source.

Parameters:
- N, 8, address/counter width in bits.
- DEPTH, 4, return-stack entries (>=1).
- RESET_VEC, 0, value loaded into q on reset (N bits).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- inc  input  1  increment q by 1.
- load  input  1  absolute jump, q <= d.
- d  input  N  jump/call target.
- rel  input  1  relative branch, q <= q + off.
- off  input  N  two's-complement branch offset.
- call  input  1  push q+1 onto the stack, then q <= d.
- ret  input  1  pop top of stack into q.
- err_clr  input  1  clear sticky err.
- q  output  N  current program counter.
- depth  output  $clog2(DEPTH+1)  number of occupied stack entries.
- full  output  1  depth == DEPTH.
- empty  output  1  depth == 0.
- err  output  1  sticky flag set on stack overflow or underflow.

Behaviour:
- Reset (reset low, asynchronous, immediate, any cycle including mid-operation):
  - q = RESET_VEC, depth = 0, empty = 1, full = 0, err = 0.
  - Stack storage contents are don't-care. Storage need not be reset; it must never be observable while empty.
- All state updates on rising clk while reset is high. Every output is registered or decoded purely from registers, so there is no combinational path from inputs to outputs.
- Latency: a command sampled at edge k is visible on q/depth/flags after edge k.
- One command per cycle. Fixed priority: load > call > ret > rel > inc > hold. Lower-priority requests asserted in the same cycle are ignored entirely, with no side effects (e.g. load+call gives no push).
- load: q <= d. Stack is untouched.
- call, not full:
  - stack[depth] <= q+1 (mod 2^N).
  - depth <= depth+1.
  - q <= d.
- call while full:
  - No push; q and depth unchanged; err <= 1 (overflow).
- ret, not empty:
  - q <= stack[depth-1]; depth <= depth-1.
- ret while empty:
  - q unchanged; err <= 1 (underflow).
- rel: q <= q + off, modulo 2^N. off is signed, so off = 2^N-1 means -1.
- inc: q <= q+1, wraps 2^N-1 -> 0.
- No command: q holds.
- Wrap-around:
  - call at q = 2^N-1 pushes 0.
  - rel crossing 0 or 2^N-1 wraps silently; no flag.
- err:
  - Sticky; cleared by err_clr on the next edge.
  - If err_clr coincides with a new overflow/underflow, set wins (err = 1).
  - err does not block further operation.
- full/empty are decoded from depth. They are never both 1 (DEPTH >= 1).
- Push then immediate pop on the next cycle returns the value just pushed (no bypass hazard, since the stack is written at the edge).

Test Plan (N=8, DEPTH=4, RESET_VEC=0x00 unless stated):
1. Hold reset low 2 cycles, release.
   - inc 1 cycle -> q=0x01.
   - load d=0xF0 -> q=0xF0.
   - inc -> q=0xF1.
   - inc+load d=0xF0 -> q=0xF0.
   - Load 0xFF, inc -> q=0x00.
2. q=0x10: call d=0x40 -> q=0x40, depth=1.
   - call d=0x80 -> q=0x80, depth=2.
   - ret -> q=0x41, depth=1.
   - ret -> q=0x11, depth=0, empty=1.
3. Four calls fill the stack -> full=1.
   - Fifth call d=0x99 -> q unchanged, depth=4, err=1.
   - err_clr -> err=0.
   - Four rets return the pushed addresses in reverse order.
   - Extra ret -> q unchanged, err=1.
4. q=0x05:
   - rel off=0xFE -> q=0x03.
   - rel off=0x7F -> q=0x82.
   - q=0xF0, rel off=0x20 -> q=0x10.
   - rel+inc together -> rel result only.
5. load+call together, d=0x33 -> q=0x33, depth unchanged.
   - call+ret with depth=1 -> call wins: depth=2, q=d.
   - err_clr and an underflow in the same cycle -> err=1.
6. Assert reset low asynchronously mid-cycle with depth=3, err=1 -> q, depth and err clear before the next edge.
   - Instance with RESET_VEC=0xA5 resets q to 0xA5.
   - After release, ret -> err=1 (stack empty).
